// File: rtl/led_pwm_driver.sv
// Three-channel LED PWM driver: follows the sequencer's one-hot colour code and
// cross-fades channel duties toward their targets once per PWM period.
module led_pwm_driver #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned STEP  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  input  logic [CNT_W-1:0] brightness,
  output logic [2:0]       led_out,
  output logic             busy
);

  localparam logic [CNT_W:0] STEP_X = (CNT_W+1)'(STEP);

  logic [2:0]       light_q;
  logic [CNT_W-1:0] bright_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty     [3];
  logic [CNT_W-1:0] target   [3];
  logic [CNT_W-1:0] duty_nxt [3];
  logic [CNT_W:0]   sum_up   [3];
  logic [CNT_W:0]   diff     [3];
  logic [2:0]       busy_vec;
  logic             period_end;

  assign period_end = (cnt == '1);

  // Non-one-hot codes other than all-off fall back to red.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) target[i] = '0;
    case (light_q)
      3'b000:  ;
      3'b010:  target[1] = bright_q;
      3'b100:  target[2] = bright_q;
      default: target[0] = bright_q;
    endcase
  end

  // One extra bit on the up-sum and the distance keeps the clamp free of wrap-around.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      duty_nxt[i] = duty[i];
      sum_up[i]   = {1'b0, duty[i]} + STEP_X;
      diff[i]     = {1'b0, duty[i]} - {1'b0, target[i]};
      busy_vec[i] = (duty[i] != target[i]);
      if (duty[i] < target[i]) begin
        duty_nxt[i] = (sum_up[i] >= {1'b0, target[i]}) ? target[i] : sum_up[i][CNT_W-1:0];
      end else if (duty[i] > target[i]) begin
        duty_nxt[i] = (diff[i] <= STEP_X) ? target[i] : duty[i] - STEP_X[CNT_W-1:0];
      end
    end
  end

  assign busy = |busy_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      light_q  <= '0;
      bright_q <= '0;
      cnt      <= '0;
      led_out  <= '0;
      for (int unsigned i = 0; i < 3; i++) duty[i] <= '0;
    end else begin
      light_q  <= light;
      bright_q <= brightness;
      cnt      <= cnt + CNT_W'(1);
      for (int unsigned i = 0; i < 3; i++) begin
        led_out[i] <= (cnt < duty[i]);
        if (period_end) duty[i] <= duty_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: per-cycle comparison against an arithmetic model,
// a steady-state vector table, and hand-written multi-cycle corner cases.
module tb_led_pwm_driver;

  localparam int P    = 256;
  localparam int STEP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light, light2;
  logic [7:0] brightness, bright2;
  logic [2:0] led_out, led2;
  logic       busy, busy2;

  int nchk = 0;
  int nerr = 0;

  int m_lq, m_bq, m_cnt;
  int m_duty [3];
  int m_led  [3];

  typedef struct {
    logic [2:0] light;
    logic [7:0] bright;
    int         h0, h1, h2;
  } vec_t;
  vec_t tbl [9];

  led_pwm_driver #(.CNT_W(8), .STEP(16)) dut (
    .clk(clk), .rst(rst), .light(light), .brightness(brightness),
    .led_out(led_out), .busy(busy)
  );

  led_pwm_driver #(.CNT_W(8), .STEP(255)) dut255 (
    .clk(clk), .rst(rst), .light(light2), .brightness(bright2),
    .led_out(led2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int tgt(input int lq, input int bq, input int i);
    if (lq == 0) return 0;
    if (lq == 1 || lq == 2 || lq == 4) return ((lq >> i) & 1) != 0 ? bq : 0;
    return (i == 0) ? bq : 0;
  endfunction

  function automatic int approach(input int d, input int t, input int s);
    if (d < t) return (d + s > t) ? t : d + s;
    if (d > t) return (d - s < t) ? t : d - s;
    return d;
  endfunction

  // Reference model: advanced at each rising edge, compared on the falling edge.
  initial begin : model
    int e_led, e_busy;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_lq = 0; m_bq = 0; m_cnt = 0;
        for (int i = 0; i < 3; i++) begin m_duty[i] = 0; m_led[i] = 0; end
      end else begin
        for (int i = 0; i < 3; i++) m_led[i] = (m_cnt < m_duty[i]) ? 1 : 0;
        if (m_cnt == P - 1)
          for (int i = 0; i < 3; i++) m_duty[i] = approach(m_duty[i], tgt(m_lq, m_bq, i), STEP);
        m_cnt = (m_cnt + 1) % P;
        m_lq  = int'(light);
        m_bq  = int'(brightness);
      end
      @(negedge clk);
      e_led  = m_led[0] | (m_led[1] << 1) | (m_led[2] << 2);
      e_busy = 0;
      for (int i = 0; i < 3; i++) if (m_duty[i] != tgt(m_lq, m_bq, i)) e_busy = 1;
      chk("model led_out", 32'(led_out), 32'(e_led));
      chk("model busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    cyc(2);
    n = 0;
    while (busy && n < bound) begin cyc(1); n++; end
    chk({nm, " settle"}, 32'(busy), 32'd0);
  endtask

  task automatic count_highs(input bit sel, output int h0, output int h1, output int h2);
    h0 = 0; h1 = 0; h2 = 0;
    repeat (P) begin
      @(negedge clk);
      if (sel) begin h0 += int'(led2[0]); h1 += int'(led2[1]); h2 += int'(led2[2]); end
      else     begin h0 += int'(led_out[0]); h1 += int'(led_out[1]); h2 += int'(led_out[2]); end
    end
  endtask

  task automatic wait_duty(input string nm, input int ch, input int val);
    int n;
    n = 0;
    while (m_duty[ch] != val && n < 8 * P) begin cyc(1); n++; end
    chk({nm, " reach duty"}, 32'(m_duty[ch]), 32'(val));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc(1);
    chk("rst led_out", 32'(led_out), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  initial begin : stim
    int h0, h1, h2, n;
    tbl[0] = '{3'b001, 8'd128, 128, 0, 0};
    tbl[1] = '{3'b001, 8'd40,   40, 0, 0};
    tbl[2] = '{3'b010, 8'd40,    0, 40, 0};
    tbl[3] = '{3'b100, 8'd255,   0, 0, 255};
    tbl[4] = '{3'b100, 8'd0,     0, 0, 0};
    tbl[5] = '{3'b110, 8'd100, 100, 0, 0};
    tbl[6] = '{3'b000, 8'd77,    0, 0, 0};
    tbl[7] = '{3'b111, 8'd255, 255, 0, 0};
    tbl[8] = '{3'b101, 8'd1,     1, 0, 0};

    rst = 1'b1; light = '0; brightness = '0; light2 = '0; bright2 = '0;
    cyc(2);
    chk("reset led_out", 32'(led_out), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      light = tbl[k].light;
      brightness = tbl[k].bright;
      wait_idle($sformatf("vec%0d", k), 20 * P);
      count_highs(1'b0, h0, h1, h2);
      chk($sformatf("vec%0d red highs", k),   32'(h0), 32'(tbl[k].h0));
      chk($sformatf("vec%0d blue highs", k),  32'(h1), 32'(tbl[k].h1));
      chk($sformatf("vec%0d green highs", k), 32'(h2), 32'(tbl[k].h2));
    end

    // Reset while blue is mid-ramp at 64.
    pulse_rst();
    light = 3'b010; brightness = 8'd255;
    wait_duty("midrst", 1, 64);
    chk("midrst busy before", 32'(busy), 32'd1);
    pulse_rst();
    cyc(1);
    chk("midrst busy after release", 32'(busy), 32'd1);
    cyc(P);
    chk("midrst restart duty", 32'(m_duty[1]), 32'd16);

    // Retarget green from 200 to 50 when its duty is 48.
    pulse_rst();
    light = 3'b100; brightness = 8'd200;
    wait_duty("retarget", 2, 48);
    brightness = 8'd50;
    wait_idle("retarget", 4 * P);
    count_highs(1'b0, h0, h1, h2);
    chk("retarget green highs", 32'(h2), 32'd50);

    for (int k = 0; k < 40; k++) begin
      light = 3'($urandom_range(0, 7));
      brightness = 8'($urandom);
      cyc($urandom_range(1, 700));
      if ($urandom_range(0, 7) == 0) pulse_rst();
    end

    // STEP=255 instance: one step up to 255, then one step down with no underflow.
    light2 = 3'b001; bright2 = 8'd255;
    cyc(2);
    n = 0;
    while (busy2 && n < 3 * P) begin cyc(1); n++; end
    chk("s255 rise settle", 32'(busy2), 32'd0);
    chk("s255 rise single step", 32'(n <= P), 32'd1);
    count_highs(1'b1, h0, h1, h2);
    chk("s255 red highs", 32'(h0), 32'd255);
    light2 = 3'b000;
    cyc(2);
    n = 0;
    while (busy2 && n < 3 * P) begin cyc(1); n++; end
    chk("s255 fall settle", 32'(busy2), 32'd0);
    chk("s255 fall single step", 32'(n <= P), 32'd1);
    count_highs(1'b1, h0, h1, h2);
    chk("s255 dark highs", 32'(h0 + h1 + h2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
